// File: rtl/fb_rect_writer_if.sv
// fb_rect_writer_if
// Bundles the signals of the rectangle-fill drawing engine into one interface.
//   Command side  : i_cmd_valid / o_cmd_ready handshake with the rectangle
//                   fields i_x0, i_y0, i_w, i_h, i_color and i_swap.
//   CRTC side     : i_screen_end, a one-cycle end-of-visible-screen pulse.
//   Write side    : o_waddr / o_wdata / o_we, the framebuffer write port, plus
//                   o_flush (buffer swap request).
//   Status        : o_busy, o_done.
// Modports: slave = the engine, master = whoever drives commands.
interface fb_rect_writer_if #(
    parameter int AW = 17,
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 3
);
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [XW-1:0] i_x0;
    logic [YW-1:0] i_y0;
    logic [XW:0]   i_w;
    logic [YW:0]   i_h;
    logic [CW-1:0] i_color;
    logic          i_swap;
    logic          i_screen_end;
    logic [AW-1:0] o_waddr;
    logic [CW-1:0] o_wdata;
    logic          o_we;
    logic          o_flush;
    logic          o_busy;
    logic          o_done;

    modport slave (
        input  i_cmd_valid, i_x0, i_y0, i_w, i_h, i_color, i_swap, i_screen_end,
        output o_cmd_ready, o_waddr, o_wdata, o_we, o_flush, o_busy, o_done
    );

    modport master (
        output i_cmd_valid, i_x0, i_y0, i_w, i_h, i_color, i_swap, i_screen_end,
        input  o_cmd_ready, o_waddr, o_wdata, o_we, o_flush, o_busy, o_done
    );
endinterface

// File: rtl/fb_rect_writer.sv
// fb_rect_writer
// Rectangle-fill engine feeding the write port of a double-buffered
// framebuffer controller. One command at a time is clipped to the screen and
// written row-major, one pixel per cycle, at address y*FB_W+x. An optional
// buffer swap is requested only after an end-of-screen pulse so flips never
// tear.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : fb_rect_writer_if.slave (command, CRTC pulse, write port, status)
module fb_rect_writer #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int AW   = 17,
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int CW   = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    fb_rect_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, WAIT_VS, FLUSH} state_t;

    localparam logic [XW+1:0] FB_W_X = (XW+2)'(FB_W);
    localparam logic [YW+1:0] FB_H_Y = (YW+2)'(FB_H);

    state_t         state_q, state_d;
    logic [XW+1:0]  x_q, x_d;
    logic [XW+1:0]  x_last_q, x_last_d;
    logic [XW-1:0]  x_first_q, x_first_d;
    logic [YW+1:0]  rows_left_q, rows_left_d;
    logic [AW-1:0]  row_base_q, row_base_d;
    logic [CW-1:0]  color_q, color_d;
    logic           swap_q, swap_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [CW-1:0]  wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           flush_q, flush_d;
    logic           done_q, done_d;

    // Clipping, evaluated on the accept cycle. Two extra bits keep x0+w and
    // y0+h from wrapping.
    logic [XW+1:0]  x_end, x_clip;
    logic [YW+1:0]  y_end, y_clip, ch;
    logic           empty_cmd;
    logic           accept;
    logic [AW-1:0]  y_base;

    assign x_end  = {2'b00, bus.i_x0} + {1'b0, bus.i_w};
    assign y_end  = {2'b00, bus.i_y0} + {1'b0, bus.i_h};
    assign x_clip = (x_end > FB_W_X) ? FB_W_X : x_end;
    assign y_clip = (y_end > FB_H_Y) ? FB_H_Y : y_end;
    assign ch     = y_clip - {2'b00, bus.i_y0};
    assign empty_cmd = ({2'b00, bus.i_x0} >= FB_W_X) || ({2'b00, bus.i_y0} >= FB_H_Y) ||
                       (bus.i_w == '0) || (bus.i_h == '0);
    // Constant multiply happens once per command, never in the pixel loop.
    assign y_base = AW'(bus.i_y0) * AW'(FB_W);

    assign bus.o_cmd_ready = (state_q == IDLE) && !i_reset;
    assign accept          = bus.i_cmd_valid && bus.o_cmd_ready;

    // Pixel-loop stepping: wrap to the left edge and add one row stride.
    logic           row_wrap;
    logic           last_pix;
    logic [XW+1:0]  x_step;
    logic [AW-1:0]  rb_step;

    assign row_wrap = (x_q == x_last_q);
    assign last_pix = row_wrap && (rows_left_q == (YW+2)'(1));
    assign x_step   = row_wrap ? {2'b00, x_first_q} : x_q + 1'b1;
    assign rb_step  = row_wrap ? row_base_q + AW'(FB_W) : row_base_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        x_last_d    = x_last_q;
        x_first_d   = x_first_q;
        rows_left_d = rows_left_q;
        row_base_d  = row_base_q;
        color_d     = color_q;
        swap_d      = swap_q;
        waddr_d     = '0;
        wdata_d     = '0;
        we_d        = 1'b0;
        flush_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_first_d = bus.i_x0;
                    x_last_d  = x_clip - 1'b1;
                    color_d   = bus.i_color;
                    swap_d    = bus.i_swap;
                    if (!empty_cmd) begin
                        state_d     = FILL;
                        x_d         = {2'b00, bus.i_x0};
                        row_base_d  = y_base;
                        rows_left_d = ch;
                        we_d        = 1'b1;
                        waddr_d     = y_base + AW'(bus.i_x0);
                        wdata_d     = bus.i_color;
                    end else if (bus.i_swap) begin
                        state_d = WAIT_VS;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (last_pix) begin
                    if (swap_q) begin
                        state_d = WAIT_VS;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    x_d        = x_step;
                    row_base_d = rb_step;
                    if (row_wrap) begin
                        rows_left_d = rows_left_q - 1'b1;
                    end
                    we_d    = 1'b1;
                    waddr_d = rb_step + AW'(x_step);
                    wdata_d = color_q;
                end
            end
            WAIT_VS: begin
                // Only pulses seen while already waiting count.
                if (bus.i_screen_end) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                // Returning to IDLE drops o_flush for a cycle, guaranteeing a
                // low gap before any following request.
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            x_last_q    <= '0;
            x_first_q   <= '0;
            rows_left_q <= '0;
            row_base_q  <= '0;
            color_q     <= '0;
            swap_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            flush_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            x_last_q    <= x_last_d;
            x_first_q   <= x_first_d;
            rows_left_q <= rows_left_d;
            row_base_q  <= row_base_d;
            color_q     <= color_d;
            swap_q      <= swap_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            flush_q     <= flush_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_waddr = waddr_q;
    assign bus.o_wdata = wdata_q;
    assign bus.o_we    = we_q;
    assign bus.o_flush = flush_q;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer
// Directed bench for fb_rect_writer: each command is applied, then the
// registered outputs are checked cycle by cycle against hand-computed values.
module tb_fb_rect_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   flush_cnt = 0;
    int   done_cnt  = 0;

    fb_rect_writer_if bus ();

    fb_rect_writer dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_flush === 1'b1) flush_cnt++;
        if (bus.o_done  === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command, waits (bounded) for acceptance, returns at T+1.
    task automatic issue(input int x0, input int y0, input int w, input int h,
                         input int c, input bit s);
        bus.i_x0 = 9'(x0);
        bus.i_y0 = 8'(y0);
        bus.i_w  = 10'(w);
        bus.i_h  = 9'(h);
        bus.i_color = 3'(c);
        bus.i_swap  = s;
        bus.i_cmd_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !bus.o_cmd_ready; i++) tick();
        check("cmd_ready_at_accept", 32'(bus.o_cmd_ready), 32'd1);
        $display("cmd x0=%0d y0=%0d w=%0d h=%0d col=%0d swap=%0d at %0t", x0, y0, w, h, c, s, $time);
        tick();
        bus.i_cmd_valid = 1'b0;
    endtask

    int exp1[4] = '{0, 1, 320, 321};
    int exp5[3] = '{0, 1, 2};

    initial begin
        bus.i_cmd_valid  = 1'b0;
        bus.i_x0 = '0; bus.i_y0 = '0; bus.i_w = '0; bus.i_h = '0;
        bus.i_color = '0; bus.i_swap = 1'b0; bus.i_screen_end = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ready", 32'(bus.o_cmd_ready), 32'd0);
        check("rst_we",    32'(bus.o_we), 32'd0);
        check("rst_flush", 32'(bus.o_flush), 32'd0);
        check("rst_done",  32'(bus.o_done), 32'd0);
        check("rst_busy",  32'(bus.o_busy), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(bus.o_cmd_ready), 32'd1);

        // 1: 2x2 fill at origin
        issue(0, 0, 2, 2, 5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("t1_we",   32'(bus.o_we), 32'd1);
            check("t1_addr", 32'(bus.o_waddr), 32'(exp1[k]));
            check("t1_data", 32'(bus.o_wdata), 32'd5);
            check("t1_nodone", 32'(bus.o_done), 32'd0);
            tick();
        end
        check("t1_we_end", 32'(bus.o_we), 32'd0);
        check("t1_done",   32'(bus.o_done), 32'd1);
        check("t1_ready",  32'(bus.o_cmd_ready), 32'd1);
        tick();
        check("t1_done_pulse", 32'(bus.o_done), 32'd0);
        check("t1_flush_cnt",  32'(flush_cnt), 32'd0);

        // 2: bottom-right corner clip -> 2 writes
        issue(318, 239, 5, 4, 3, 1'b0);
        check("t2_we0",   32'(bus.o_we), 32'd1);
        check("t2_addr0", 32'(bus.o_waddr), 32'd76798);
        check("t2_data0", 32'(bus.o_wdata), 32'd3);
        tick();
        check("t2_we1",   32'(bus.o_we), 32'd1);
        check("t2_addr1", 32'(bus.o_waddr), 32'd76799);
        tick();
        check("t2_we_end", 32'(bus.o_we), 32'd0);
        check("t2_done",   32'(bus.o_done), 32'd1);
        tick();

        // 3: empty commands
        issue(320, 0, 4, 4, 1, 1'b0);
        check("t3a_we",   32'(bus.o_we), 32'd0);
        check("t3a_done", 32'(bus.o_done), 32'd1);
        check("t3a_busy", 32'(bus.o_busy), 32'd0);
        tick();
        issue(10, 10, 0, 3, 1, 1'b0);
        check("t3b_we",   32'(bus.o_we), 32'd0);
        check("t3b_done", 32'(bus.o_done), 32'd1);
        tick();

        // 4: single pixel with swap; pulse on the entry edge is ignored
        issue(10, 1, 1, 1, 7, 1'b1);
        check("t4_we",   32'(bus.o_we), 32'd1);
        check("t4_addr", 32'(bus.o_waddr), 32'd330);
        check("t4_data", 32'(bus.o_wdata), 32'd7);
        bus.i_screen_end = 1'b1;
        tick();
        bus.i_screen_end = 1'b0;
        check("t4_we_off", 32'(bus.o_we), 32'd0);
        check("t4_busy",   32'(bus.o_busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("t4_wait_flush", 32'(bus.o_flush), 32'd0);
            check("t4_wait_done",  32'(bus.o_done), 32'd0);
            tick();
        end
        bus.i_screen_end = 1'b1;
        tick();
        bus.i_screen_end = 1'b0;
        check("t4_flush",  32'(bus.o_flush), 32'd1);
        check("t4_fl_nodone", 32'(bus.o_done), 32'd0);
        tick();
        check("t4_flush_off", 32'(bus.o_flush), 32'd0);
        check("t4_done",   32'(bus.o_done), 32'd1);
        check("t4_ready",  32'(bus.o_cmd_ready), 32'd1);
        check("t4_flush_cnt", 32'(flush_cnt), 32'd1);
        tick();

        // 5: reset in the middle of a 4x4 fill
        issue(0, 0, 4, 4, 6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("t5_we",   32'(bus.o_we), 32'd1);
            check("t5_addr", 32'(bus.o_waddr), 32'(exp5[k]));
            if (k < 2) tick();
        end
        rst = 1'b1;
        #1;
        check("t5_ready_in_rst", 32'(bus.o_cmd_ready), 32'd0);
        begin
            int d0;
            d0 = done_cnt;
            tick();
            check("t5_we_off", 32'(bus.o_we), 32'd0);
            check("t5_done",   32'(bus.o_done), 32'd0);
            check("t5_flush",  32'(bus.o_flush), 32'd0);
            check("t5_busy",   32'(bus.o_busy), 32'd0);
            rst = 1'b0;
            #1;
            check("t5_ready_after", 32'(bus.o_cmd_ready), 32'd1);
            for (int k = 0; k < 4; k++) tick();
            check("t5_no_done",  32'(done_cnt), 32'(d0));
            check("t5_no_flush", 32'(flush_cnt), 32'd1);
        end

        // 6: back-to-back commands with valid held high
        bus.i_x0 = 9'd0; bus.i_y0 = 8'd0; bus.i_w = 10'd2; bus.i_h = 9'd1;
        bus.i_color = 3'd1; bus.i_swap = 1'b0; bus.i_cmd_valid = 1'b1;
        #1;
        check("t6_ready_a", 32'(bus.o_cmd_ready), 32'd1);
        $display("cmd A held-valid at %0t", $time);
        tick();
        bus.i_x0 = 9'd5; bus.i_y0 = 8'd5; bus.i_w = 10'd1; bus.i_h = 9'd2; bus.i_color = 3'd2;
        check("t6_a_addr0", 32'(bus.o_waddr), 32'd0);
        check("t6_a_busy_ready", 32'(bus.o_cmd_ready), 32'd0);
        tick();
        check("t6_a_addr1", 32'(bus.o_waddr), 32'd1);
        check("t6_a_we1",   32'(bus.o_we), 32'd1);
        tick();
        check("t6_a_done",  32'(bus.o_done), 32'd1);
        check("t6_b_ready", 32'(bus.o_cmd_ready), 32'd1);
        $display("cmd B accepted at %0t", $time);
        tick();
        bus.i_cmd_valid = 1'b0;
        check("t6_b_we0",   32'(bus.o_we), 32'd1);
        check("t6_b_addr0", 32'(bus.o_waddr), 32'd1605);
        check("t6_b_data0", 32'(bus.o_wdata), 32'd2);
        tick();
        check("t6_b_we1",   32'(bus.o_we), 32'd1);
        check("t6_b_addr1", 32'(bus.o_waddr), 32'd1925);
        tick();
        check("t6_b_done",  32'(bus.o_done), 32'd1);
        check("t6_b_we_off", 32'(bus.o_we), 32'd0);
        tick();
        check("t6_idle", 32'(bus.o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
